// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: ALU results pass through in one cycle, aligned
// loads/stores stall upstream for LATENCY+1 cycles while the data memory is accessed.
module mem_access_stage #(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        in_memread,
    input  logic        in_memwrite,
    input  logic        in_regwrite,
    input  logic        in_memtoreg,
    input  logic [4:0]  in_rd,
    input  logic [63:0] in_addr,
    input  logic [63:0] in_wdata,
    input  logic [63:0] in_alu,
    output logic        stall,
    output logic        out_valid,
    output logic        out_regwrite,
    output logic [4:0]  out_rd,
    output logic [63:0] out_wbdata,
    output logic        misalign_err
);

    localparam int IDXW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state_reg, state_next;
    logic [3:0]        count_reg, count_next;

    logic              cap_store_reg;
    logic              cap_memtoreg_reg;
    logic              cap_regwrite_reg;
    logic [4:0]        cap_rd_reg;
    logic [IDXW-1:0]   cap_index_reg;
    logic [63:0]       cap_wdata_reg;
    logic [63:0]       cap_alu_reg;

    logic [63:0]       mem [DEPTH];
    logic [63:0]       rdata_reg;

    logic              mem_op;
    logic              aligned;
    logic              accept_mem;
    logic              unused_addr_bits;

    assign mem_op     = in_memread | in_memwrite;
    assign aligned    = (in_addr[2:0] == 3'b000);
    assign accept_mem = (state_reg == IDLE) && in_valid && mem_op && aligned;
    assign stall      = (state_reg != IDLE);

    // Address bits above the word index are deliberately ignored (wrap-around).
    assign unused_addr_bits = ^in_addr[63:IDXW+3];

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        case (state_reg)
            IDLE: begin
                if (accept_mem) begin
                    state_next = ACCESS;
                    count_next = 4'(LATENCY - 1);
                end
            end
            ACCESS: begin
                if (count_reg == 4'd0) begin
                    state_next = RESP;
                end else begin
                    count_next = count_reg - 4'd1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                count_next = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            count_reg <= 4'd0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    // Everything the access needs is frozen at accept so upstream may change freely.
    always_ff @(posedge clock) begin
        if (reset) begin
            cap_store_reg    <= 1'b0;
            cap_memtoreg_reg <= 1'b0;
            cap_regwrite_reg <= 1'b0;
            cap_rd_reg       <= 5'd0;
            cap_index_reg    <= '0;
            cap_wdata_reg    <= 64'd0;
            cap_alu_reg      <= 64'd0;
        end else if (accept_mem) begin
            cap_store_reg    <= in_memwrite;
            cap_memtoreg_reg <= in_memtoreg;
            cap_regwrite_reg <= in_regwrite;
            cap_rd_reg       <= in_rd;
            cap_index_reg    <= in_addr[IDXW+2:3];
            cap_wdata_reg    <= in_wdata;
            cap_alu_reg      <= in_alu;
        end
    end

    // Block RAM with registered read; the read address is stable throughout ACCESS,
    // so rdata_reg holds the addressed word by the time RESP retires.
    always_ff @(posedge clock) begin
        if (!reset && (state_reg == RESP) && cap_store_reg) begin
            mem[cap_index_reg] <= cap_wdata_reg;
        end
        rdata_reg <= mem[cap_index_reg];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_regwrite <= 1'b0;
            out_rd       <= 5'd0;
            out_wbdata   <= 64'd0;
            misalign_err <= 1'b0;
        end else begin
            out_valid    <= 1'b0;
            misalign_err <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (in_valid && !mem_op) begin
                        out_valid    <= 1'b1;
                        out_regwrite <= in_regwrite;
                        out_rd       <= in_rd;
                        out_wbdata   <= in_alu;
                    end else if (in_valid && !aligned) begin
                        out_valid    <= 1'b1;
                        misalign_err <= 1'b1;
                        out_regwrite <= 1'b0;
                        out_rd       <= in_rd;
                        out_wbdata   <= 64'd0;
                    end
                end
                RESP: begin
                    out_valid    <= 1'b1;
                    out_rd       <= cap_rd_reg;
                    out_regwrite <= cap_store_reg ? 1'b0 : cap_regwrite_reg;
                    out_wbdata   <= (!cap_store_reg && cap_memtoreg_reg) ? rdata_reg : cap_alu_reg;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter DEPTH, default 32, number of 64-bit data-memory words (power of two, 2..256).
REQ-002 Parameter LATENCY, default 2, memory access cycles per load/store (1..15).
REQ-003 clock  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising edge of clock.
REQ-005 in_valid  input  1  a stage-register entry is presented this cycle.
REQ-006 in_memread  input  1  load request.
REQ-007 in_memwrite  input  1  store request.
REQ-008 in_regwrite  input  1  instruction writes a register.
REQ-009 in_memtoreg  input  1  writeback source: 1 = loaded data, 0 = ALU result.
REQ-010 in_rd  input  5  destination register.
REQ-011 in_addr  input  64  byte address (ALU result used as address).
REQ-012 in_wdata  input  64  store data.
REQ-013 in_alu  input  64  ALU result for non-load writeback.
REQ-014 stall  output  1  upstream shall hold its stage register while high.
REQ-015 out_valid  output  1  one-cycle pulse per retired entry.
REQ-016 out_regwrite  output  1  writeback enable, qualified by out_valid.
REQ-017 out_rd  output  5  writeback destination.
REQ-018 out_wbdata  output  64  writeback data.
REQ-019 misalign_err  output  1  one-cycle pulse with out_valid for a misaligned memory access.

Function
REQ-020 FSM states IDLE, ACCESS, RESP; stall = (state != IDLE), combinational from state only.
REQ-021 IDLE, in_valid=1, in_memread=0, in_memwrite=0: next edge registers out_valid=1, out_regwrite=in_regwrite, out_rd=in_rd, out_wbdata=in_alu; state stays IDLE (latency 1, no stall).
REQ-022 IDLE, in_valid=1, memread or memwrite, in_addr[2:0]=0: capture all inputs, enter ACCESS, load counter with LATENCY-1.
REQ-023 ACCESS: counter decrements each cycle; at 0 enter RESP on next edge; total cycles from accept edge to RESP entry = LATENCY.
REQ-024 RESP edge: perform memory op, set out_valid=1, return to IDLE; stall therefore high for exactly LATENCY+1 cycles... no: stall high for LATENCY cycles in ACCESS plus 1 in RESP.
REQ-025 Word index = in_addr[log2(DEPTH)+2:3]; higher address bits ignored (address wraps modulo DEPTH*8).
REQ-026 Load: out_wbdata = in_memtoreg ? mem[index] : captured in_alu; out_regwrite = captured in_regwrite.
REQ-027 Store: mem[index] <= captured in_wdata on the RESP edge only; out_regwrite=0; out_wbdata=captured in_alu.
REQ-028 memread and memwrite both set: treated as store; out_regwrite=0.
REQ-029 Misaligned (in_addr[2:0]!=0) memory op in IDLE: no memory access, no stall; next edge out_valid=1, misalign_err=1, out_regwrite=0, out_rd=in_rd, out_wbdata=0.
REQ-030 Inputs ignored while stall=1; out_valid, misalign_err low in every cycle not retiring an entry; out_rd/out_wbdata hold last value.
REQ-031 Load after store to same index returns the stored value (write commits before next accept).
REQ-032 in_valid=0 in IDLE: no state change, out_valid=0.

Reset
REQ-033 reset=1: state IDLE, counter 0, stall 0, out_valid 0, out_regwrite 0, out_rd 0, out_wbdata 0, misalign_err 0.
REQ-034 reset during ACCESS/RESP aborts the operation: no memory write, no out_valid.
REQ-035 Memory contents are not cleared by reset; reset has priority over all inputs.

Verification
REQ-036 ALU op rd=5, alu=0x1234, regwrite=1 -> next cycle out_valid=1, out_rd=5, out_wbdata=0x1234, stall never high.
REQ-037 Store addr=0x18, wdata=0xDEADBEEF, then load addr=0x18 memtoreg=1 rd=3 (LATENCY=2) -> stall high 3 cycles each; load retires out_wbdata=0xDEADBEEF, out_regwrite=1.
REQ-038 Load addr=0x100+0x18 (DEPTH=32) -> wraps to index 3, returns 0xDEADBEEF.
REQ-039 Load addr=0x1C -> next cycle out_valid=1, misalign_err=1, out_regwrite=0, no stall.
REQ-040 Store addr=0x20 wdata=0x55, reset asserted in ACCESS -> outputs zero, later load addr=0x20 returns prior contents, not 0x55.
REQ-041 memread=memwrite=1 addr=0x28 wdata=0x77 -> out_regwrite=0; subsequent load addr=0x28 returns 0x77.
